pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the out-of-order core pipeline. It drives the `stall_current_stage`, `stall_next_stage` and `flush` inputs of every pipeline register: fetch, decode, rename, ROB allocate, ROB/issue and issue. It resolves per-stage stall requests into a back-to-front stall chain. It also serialises redirects (commit-time exceptions, branch mispredicts) into a single-cycle flush with its redirect PC, and waits for the store buffer to drain before an exception flush.

---
 rtl/pipeline_ctrl.sv | 102 ++++++++++
 tb/tb_pipeline_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall chain resolution and redirect/flush sequencing.
// Ports: clk, rst, stall_req, exc_req/exc_pc, mispredict_req/mispredict_pc, sb_empty -> stall, flush, flush_pc, busy.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif

module pipeline_ctrl #(
    parameter int STAGE_NUM = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STAGE_NUM-1:0] stall_req,
    input  logic                 exc_req,
    input  logic [`ADDR_BUS]     exc_pc,
    input  logic                 mispredict_req,
    input  logic [`ADDR_BUS]     mispredict_pc,
    input  logic                 sb_empty,
    output logic [STAGE_NUM-1:0] stall,
    output logic                 flush,
    output logic [`ADDR_BUS]     flush_pc,
    output logic                 busy
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_DRAIN = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [`ADDR_BUS]       r_pend_pc;
    logic [`ADDR_BUS]       r_flush_pc;
    logic [STAGE_NUM-1:0]   w_chain;

    // State and redirect PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pend_pc  <= '0;
            r_flush_pc <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                RUN: begin
                    if (exc_req) begin
                        if (sb_empty) r_flush_pc <= exc_pc;
                        else          r_pend_pc  <= exc_pc;
                    end else if (mispredict_req) begin
                        r_flush_pc <= mispredict_pc;
                    end
                end
                WAIT_DRAIN: begin
                    if (sb_empty) r_flush_pc <= r_pend_pc;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; exception beats a same-cycle mispredict.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN: begin
                if (exc_req)             w_next = sb_empty ? FLUSH : WAIT_DRAIN;
                else if (mispredict_req) w_next = FLUSH;
            end
            WAIT_DRAIN: begin
                if (sb_empty) w_next = FLUSH;
            end
            FLUSH:   w_next = RUN;
            default: w_next = RUN;
        endcase
    end

    // A stalled stage freezes every stage in front of it.
    always_comb begin
        w_chain = '0;
        w_chain[STAGE_NUM-1] = stall_req[STAGE_NUM-1];
        for (int i = STAGE_NUM - 2; i >= 0; i--) begin
            w_chain[i] = stall_req[i] | w_chain[i+1];
        end
    end

    // Outputs.
    always_comb begin
        stall = '0;
        flush = 1'b0;
        case (r_state)
            RUN:        stall = w_chain;
            WAIT_DRAIN: stall = '1;
            FLUSH:      flush = 1'b1;
            default:    stall = '0;
        endcase
        if (rst) stall = '0;
    end

    assign flush_pc = r_flush_pc;
    assign busy     = (r_state != RUN);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector bench for pipeline_ctrl.
// Drives inputs just after the rising edge and checks outputs 1 ns later.
`timescale 1ns/1ps

module tb_pipeline_ctrl;

    localparam int SN = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [SN-1:0] stall_req;
    logic          exc_req;
    logic [31:0]   exc_pc;
    logic          mispredict_req;
    logic [31:0]   mispredict_pc;
    logic          sb_empty;
    logic [SN-1:0] stall;
    logic          flush;
    logic [31:0]   flush_pc;
    logic          busy;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.STAGE_NUM(SN)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_req      (stall_req),
        .exc_req        (exc_req),
        .exc_pc         (exc_pc),
        .mispredict_req (mispredict_req),
        .mispredict_pc  (mispredict_pc),
        .sb_empty       (sb_empty),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_req = 6'h3F;
        #1;
        checks++;
        if (stall !== 6'h00) begin
            errors++;
            $display("FAIL reset_stall got %b want %b", stall, 6'h00);
        end
        step();
        step();
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0 || flush_pc !== 32'h0 || stall !== 6'h00) begin
            errors++;
            $display("FAIL reset_state got flush=%b busy=%b pc=%h stall=%b want 0 0 0 0",
                     flush, busy, flush_pc, stall);
        end
        rst = 1'b0;
        stall_req = '0;
        step();
    endtask

    task automatic test_stall_chain();
        logic [SN-1:0] req [4] = '{6'b001000, 6'b100001, 6'b000001, 6'b000000};
        logic [SN-1:0] exp [4] = '{6'b001111, 6'b111111, 6'b000001, 6'b000000};
        for (int i = 0; i < 4; i++) begin
            stall_req = req[i];
            #1;
            checks++;
            if (stall !== exp[i] || flush !== 1'b0) begin
                errors++;
                $display("FAIL stall_chain[%0d] got stall=%b flush=%b want %b 0",
                         i, stall, flush, exp[i]);
            end
        end
        step();
    endtask

    task automatic test_mispredict();
        mispredict_req = 1'b1;
        mispredict_pc  = 32'hBFC0_0100;
        stall_req      = 6'b000100;
        step();
        mispredict_req = 1'b0;
        mispredict_pc  = 32'h0;
        #1;
        checks++;
        if (flush !== 1'b1 || flush_pc !== 32'hBFC0_0100 || stall !== 6'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mispredict_flush got f=%b pc=%h st=%b b=%b want 1 bfc00100 000000 1",
                     flush, flush_pc, stall, busy);
        end
        step();
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0 || stall !== 6'b000111) begin
            errors++;
            $display("FAIL mispredict_after got f=%b b=%b st=%b want 0 0 000111",
                     flush, busy, stall);
        end
        stall_req = '0;
    endtask

    task automatic test_exc_drain();
        exc_req  = 1'b1;
        exc_pc   = 32'hBFC0_0380;
        sb_empty = 1'b0;
        step();
        exc_req = 1'b0;
        exc_pc  = 32'h0;
        for (int c = 0; c < 3; c++) begin
            mispredict_req = (c == 1);
            mispredict_pc  = 32'h1234_5678;
            #1;
            checks++;
            if (stall !== 6'h3F || flush !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL drain_wait[%0d] got st=%b f=%b b=%b want 111111 0 1",
                         c, stall, flush, busy);
            end
            step();
        end
        mispredict_req = 1'b0;
        checks++;
        if (flush !== 1'b0 || stall !== 6'h3F) begin
            errors++;
            $display("FAIL drain_ignore_misp got f=%b st=%b want 0 111111", flush, stall);
        end
        sb_empty = 1'b1;
        step();
        checks++;
        if (flush !== 1'b1 || flush_pc !== 32'hBFC0_0380 || stall !== 6'h00) begin
            errors++;
            $display("FAIL drain_flush got f=%b pc=%h st=%b want 1 bfc00380 000000",
                     flush, flush_pc, stall);
        end
        step();
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_done got f=%b b=%b want 0 0", flush, busy);
        end
    endtask

    task automatic test_simultaneous();
        exc_req        = 1'b1;
        exc_pc         = 32'h8000_0180;
        mispredict_req = 1'b1;
        mispredict_pc  = 32'h8000_1000;
        sb_empty       = 1'b1;
        step();
        exc_req        = 1'b0;
        mispredict_req = 1'b0;
        checks++;
        if (flush !== 1'b1 || flush_pc !== 32'h8000_0180) begin
            errors++;
            $display("FAIL simul_flush got f=%b pc=%h want 1 80000180", flush, flush_pc);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (flush !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL simul_single[%0d] got f=%b b=%b want 0 0", c, flush, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        mispredict_req = 1'b1;
        mispredict_pc  = 32'h0000_1000;
        step();
        checks++;
        if (flush !== 1'b1 || flush_pc !== 32'h0000_1000) begin
            errors++;
            $display("FAIL b2b_first got f=%b pc=%h want 1 00001000", flush, flush_pc);
        end
        mispredict_pc = 32'h0000_2000;
        step();
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0 || flush_pc !== 32'h0000_1000) begin
            errors++;
            $display("FAIL b2b_ignored got f=%b b=%b pc=%h want 0 0 00001000",
                     flush, busy, flush_pc);
        end
        mispredict_pc = 32'h0000_3000;
        step();
        mispredict_req = 1'b0;
        checks++;
        if (flush !== 1'b1 || flush_pc !== 32'h0000_3000) begin
            errors++;
            $display("FAIL b2b_second got f=%b pc=%h want 1 00003000", flush, flush_pc);
        end
        step();
        checks++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got f=%b want 0", flush);
        end
    endtask

    task automatic test_reset_mid_drain();
        exc_req  = 1'b1;
        exc_pc   = 32'hDEAD_BEE0;
        sb_empty = 1'b0;
        step();
        exc_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || stall !== 6'h3F) begin
            errors++;
            $display("FAIL rdrain_enter got b=%b st=%b want 1 111111", busy, stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 6'h00 || flush !== 1'b0) begin
            errors++;
            $display("FAIL rdrain_in_rst got st=%b f=%b want 000000 0", stall, flush);
        end
        step();
        rst      = 1'b0;
        sb_empty = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0 || stall !== 6'h00) begin
            errors++;
            $display("FAIL rdrain_after got f=%b b=%b st=%b want 0 0 000000",
                     flush, busy, stall);
        end
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (flush !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rdrain_noflush[%0d] got f=%b b=%b want 0 0", c, flush, busy);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        stall_req      = '0;
        exc_req        = 1'b0;
        exc_pc         = '0;
        mispredict_req = 1'b0;
        mispredict_pc  = '0;
        sb_empty       = 1'b1;
        test_reset();
        test_stall_chain();
        test_mispredict();
        test_exc_drain();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
